// File: rtl/host_cycle_sync.sv
// Fast-domain host bus-cycle sequencer: measures the host clock period from the edge pulse,
// tracks lock, and lets each CPU access occupy exactly one host cycle, edge to edge.
module host_cycle_sync #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MIN_PERIOD = 5
) (
    input  logic             clk,
    input  logic             srst_b,
    input  logic             edge_in,
    input  logic             req,
    output logic             hold,
    output logic             host_en,
    output logic             ack,
    output logic             err,
    output logic [CNT_W-1:0] period,
    output logic             locked
);

    typedef enum logic [1:0] {StIdle, StWaitEdge, StActive, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(MIN_PERIOD);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             locked_q, locked_d;
    logic             prev_ok_q, prev_ok_d;
    logic             host_en_q, host_en_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             cnt_sat;
    logic             ok;

    assign cnt_sat = (cnt_q == CntMax);
    assign ok      = (cnt_q >= MinPeriod) && !cnt_sat;

    // Period counter and lock; cnt stays 0 until the first edge so that edge never counts as valid.
    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        prev_ok_d = prev_ok_q;
        locked_d  = locked_q;
        if (edge_in) begin
            period_d  = cnt_q;
            cnt_d     = CntOne;
            prev_ok_d = ok;
            locked_d  = ok & prev_ok_q;
        end else if ((cnt_q != '0) && !cnt_sat) begin
            cnt_d = cnt_q + CntOne;
        end
        if (!edge_in && (cnt_d == CntMax)) begin
            locked_d  = 1'b0;
            prev_ok_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) state_d = StWaitEdge;
            end
            StWaitEdge: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (edge_in && locked_q) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                // A saturated counter means the host clock vanished mid-access.
                if (cnt_sat) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (edge_in) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        host_en_d = (state_d == StActive);
        ack_d     = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!srst_b) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            period_q  <= '0;
            locked_q  <= 1'b0;
            prev_ok_q <= 1'b0;
            host_en_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            locked_q  <= locked_d;
            prev_ok_q <= prev_ok_d;
            host_en_q <= host_en_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign hold    = srst_b & req & (state_q != StDone);
    assign host_en = host_en_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign period  = period_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_host_cycle_sync.sv
// Directed bench for host_cycle_sync: a per-cycle vector table for lock-up and one access,
// then hand-written sequences for short periods, timeout, reset mid-access and back-to-back.
module tb_host_cycle_sync;

    logic       clk = 1'b0;
    logic       srst_b, edge_in, req;
    logic       hold, host_en, ack, err, locked;
    logic [7:0] period;

    logic       s4, e4, r4;
    logic       hold4, host_en4, ack4, err4, locked4;
    logic [3:0] period4;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       e, r, s;
        logic       hold, hen, ack, err, lck;
        logic [7:0] per;
    } vec_t;

    vec_t vecs[57];

    host_cycle_sync #(.CNT_W(8), .MIN_PERIOD(5)) dut (
        .clk(clk), .srst_b(srst_b), .edge_in(edge_in), .req(req),
        .hold(hold), .host_en(host_en), .ack(ack), .err(err),
        .period(period), .locked(locked)
    );

    host_cycle_sync #(.CNT_W(4), .MIN_PERIOD(5)) dut4 (
        .clk(clk), .srst_b(s4), .edge_in(e4), .req(r4),
        .hold(hold4), .host_en(host_en4), .ack(ack4), .err(err4),
        .period(period4), .locked(locked4)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input int cyc, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk8(input string name, input int cyc, input logic [7:0] act,
                        input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic r, input logic s);
        edge_in = e;
        req     = r;
        srst_b  = s;
        #1;
    endtask

    task automatic drive4(input logic e, input logic r, input logic s);
        e4 = e;
        r4 = r;
        s4 = s;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        s4 = 1'b0; e4 = 1'b0; r4 = 1'b0;

        // Reset through cycle 9, edges every 6 from 10, one access requested at 42.
        for (int k = 0; k < 57; k++) begin
            vecs[k].s    = (k >= 10);
            vecs[k].e    = (k >= 10) && (k <= 52) && ((k - 10) % 6 == 0);
            vecs[k].r    = (k >= 42) && (k <= 52);
            vecs[k].hold = (k >= 42) && (k <= 52);
            vecs[k].hen  = (k >= 47) && (k <= 52);
            vecs[k].ack  = (k == 53);
            vecs[k].err  = 1'b0;
            vecs[k].lck  = (k >= 23);
            vecs[k].per  = (k >= 17) ? 8'd6 : 8'd0;
        end

        for (int k = 0; k < 57; k++) begin
            drive(vecs[k].e, vecs[k].r, vecs[k].s);
            if (k > 0) begin
                chk1("tbl_hold", k, hold, vecs[k].hold);
                chk1("tbl_host_en", k, host_en, vecs[k].hen);
                chk1("tbl_ack", k, ack, vecs[k].ack);
                chk1("tbl_err", k, err, vecs[k].err);
                chk1("tbl_locked", k, locked, vecs[k].lck);
                chk8("tbl_period", k, period, vecs[k].per);
            end
            tick();
        end

        // Edges every 4 cycles: never locks, access never starts.
        drive(1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0); tick();
        for (int c = 0; c < 40; c++) begin
            drive((c % 4) == 0, 1'b1, 1'b1);
            chk1("short_locked", c, locked, 1'b0);
            chk1("short_host_en", c, host_en, 1'b0);
            chk1("short_hold", c, hold, 1'b1);
            if (c >= 5) chk8("short_period", c, period, 8'd4);
            tick();
        end

        // Lock, start an access, reset for one cycle mid-ACTIVE, relock, then two
        // back-to-back accesses with req held high.
        drive(1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0); tick();
        for (int c = 0; c <= 64; c++) begin
            logic exp_hen, exp_ack, exp_lck;
            drive((c % 6) == 0, c >= 14, c != 21);
            exp_hen = ((c >= 19) && (c <= 21)) || ((c >= 43) && (c <= 48)) ||
                      ((c >= 55) && (c <= 60));
            exp_ack = (c == 49) || (c == 61);
            exp_lck = ((c >= 13) && (c <= 21)) || (c >= 37);
            chk1("rst_host_en", c, host_en, exp_hen);
            chk1("rst_ack", c, ack, exp_ack);
            chk1("rst_err", c, err, 1'b0);
            chk1("rst_locked", c, locked, exp_lck);
            if (c <= 6 || (c >= 22 && c <= 24)) chk8("rst_period", c, period, 8'd0);
            if ((c >= 7 && c <= 21) || c >= 31) chk8("rst_period", c, period, 8'd6);
            if (c == 21 || c == 49 || c == 61) chk1("rst_hold", c, hold, 1'b0);
            if (c == 50 || c == 54) chk1("rst_hold", c, hold, 1'b1);
            tick();
        end

        // CNT_W = 4: lock, enter ACTIVE on the edge at 18, then the host clock stops.
        drive(1'b0, 1'b0, 1'b0);
        drive4(1'b0, 1'b0, 1'b0); tick();
        drive4(1'b0, 1'b0, 1'b0); tick();
        for (int c = 0; c <= 36; c++) begin
            drive4((c <= 18) && ((c % 6) == 0), (c >= 14) && (c <= 34), 1'b1);
            chk1("to_locked", c, locked4, (c >= 13) && (c <= 32));
            chk1("to_host_en", c, host_en4, (c >= 19) && (c <= 33));
            chk1("to_ack", c, ack4, c == 34);
            chk1("to_err", c, err4, c == 34);
            if (c >= 7) chk8("to_period", c, {4'b0, period4}, 8'd6);
            if (c == 33) chk1("to_hold", c, hold4, 1'b1);
            if (c == 34) chk1("to_hold", c, hold4, 1'b0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
